// File: rtl/bship_pkg.sv
// Shared phase encoding, widths and cursor helper for the Battleship sequencer.
// Build option: BSHIP_AUTO_REPEAT_EN (see bship_game_ctrl) enables hold-to-repeat.
package bship_pkg;

  localparam int GRID_N  = 10;
  localparam int CUR_W   = 4;
  localparam int TURNS_W = 5;
  localparam int SHIPS_W = 3;
  localparam int SHOT_W  = 7;

  localparam logic [SHOT_W-1:0] SHOT_MAX = 7'd127;

  typedef enum logic [2:0] {
    TITLE  = 3'd0,
    CLEAR  = 3'd1,
    PLAY   = 3'd2,
    SETTLE = 3'd3,
    WON    = 3'd4,
    LOST   = 3'd5
  } phase_e;

  // One cursor step with wrap-around on a 0..n-1 axis.
  function automatic logic [CUR_W-1:0] wrap_step(
    input logic [CUR_W-1:0] v,
    input logic             dec,
    input int               n
  );
    logic [CUR_W-1:0] top;
    top = CUR_W'(n - 1);
    if (dec) return (v == '0) ? top : v - 1'b1;
    return (v == top) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/bship_btn_repeat.sv
// Button rising-edge detector with optional hold-to-repeat.
// Emits a registered one-cycle strobe per accepted press or repeat tick.
module bship_btn_repeat #(
  parameter int unsigned DELAY     = 8,
  parameter int unsigned RATE      = 4,
  parameter bit          REPEAT_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic en,
  output logic strobe
);

  localparam int unsigned MAXC = (DELAY > RATE) ? DELAY : RATE;
  localparam int          CW   = $clog2(MAXC + 1);

  logic          btn_d_q;
  logic          active_q, active_d;
  logic          strobe_q, strobe_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise;
  logic          fire;

  // Counter runs down from the edge; zero while held means a repeat tick.
  always_comb begin
    rise     = btn & ~btn_d_q;
    fire     = 1'b0;
    active_d = 1'b0;
    cnt_d    = '0;
    if (REPEAT_EN && en && btn) begin
      if (rise) begin
        active_d = 1'b1;
        cnt_d    = CW'(DELAY - 1);
      end else if (active_q) begin
        active_d = 1'b1;
        if (cnt_q == '0) begin
          fire  = 1'b1;
          cnt_d = CW'(RATE - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
    strobe_d = rise | fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_d_q  <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      btn_d_q  <= btn;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/bship_game_ctrl.sv
// Battleship top sequencer: phase FSM, cursor, bomb/clear pulses, shot count.
// Define BSHIP_AUTO_REPEAT_EN to enable hold-to-repeat cursor movement.
module bship_game_ctrl #(
  parameter int          GRID_N        = bship_pkg::GRID_N,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_RATE   = 10_000_000,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         btn_u,
  input  logic                         btn_d,
  input  logic                         btn_l,
  input  logic                         btn_r,
  input  logic                         btn_c,
  input  logic [bship_pkg::TURNS_W-1:0] turns_left,
  input  logic [bship_pkg::SHIPS_W-1:0] ships_remaining,
  output logic [bship_pkg::CUR_W-1:0]   sprite_row,
  output logic [bship_pkg::CUR_W-1:0]   sprite_col,
  output logic                         bomb,
  output logic                         board_clear,
  output logic [2:0]                   phase,
  output logic [bship_pkg::SHOT_W-1:0]  shots_fired
);

  import bship_pkg::*;

`ifdef BSHIP_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  localparam int SW = $clog2(SETTLE_CYCLES);

  phase_e            phase_q, phase_d;
  logic [CUR_W-1:0]  row_q, row_d;
  logic [CUR_W-1:0]  col_q, col_d;
  logic [SHOT_W-1:0] shots_q, shots_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              bomb_q, bomb_d;
  logic              clr_q, clr_d;
  logic              start_clr;
  logic              in_play;
  logic              mv_u, mv_d, mv_l, mv_r, fire_c;

  assign in_play = (phase_q == PLAY);

  bship_btn_repeat #(
    .DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE), .REPEAT_EN(REP_EN)
  ) u_btn_u (
    .clk(clk), .rst_n(reset_n), .btn(btn_u), .en(in_play), .strobe(mv_u)
  );

  bship_btn_repeat #(
    .DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE), .REPEAT_EN(REP_EN)
  ) u_btn_d (
    .clk(clk), .rst_n(reset_n), .btn(btn_d), .en(in_play), .strobe(mv_d)
  );

  bship_btn_repeat #(
    .DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE), .REPEAT_EN(REP_EN)
  ) u_btn_l (
    .clk(clk), .rst_n(reset_n), .btn(btn_l), .en(in_play), .strobe(mv_l)
  );

  bship_btn_repeat #(
    .DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE), .REPEAT_EN(REP_EN)
  ) u_btn_r (
    .clk(clk), .rst_n(reset_n), .btn(btn_r), .en(in_play), .strobe(mv_r)
  );

  bship_btn_repeat #(
    .DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE), .REPEAT_EN(1'b0)
  ) u_btn_c (
    .clk(clk), .rst_n(reset_n), .btn(btn_c), .en(1'b0), .strobe(fire_c)
  );

  always_comb begin
    phase_d   = phase_q;
    row_d     = row_q;
    col_d     = col_q;
    shots_d   = shots_q;
    settle_d  = settle_q;
    bomb_d    = 1'b0;
    clr_d     = 1'b0;
    start_clr = 1'b0;
    unique case (phase_q)
      TITLE, WON, LOST: start_clr = fire_c;
      CLEAR: phase_d = PLAY;
      PLAY: begin
        // Fire wins; any direction strobe in the same cycle is dropped.
        if (fire_c) begin
          bomb_d   = 1'b1;
          settle_d = SW'(SETTLE_CYCLES - 1);
          phase_d  = SETTLE;
          if (shots_q != SHOT_MAX) shots_d = shots_q + 1'b1;
        end else begin
          if (mv_u)      row_d = wrap_step(row_q, 1'b1, GRID_N);
          else if (mv_d) row_d = wrap_step(row_q, 1'b0, GRID_N);
          if (mv_l)      col_d = wrap_step(col_q, 1'b1, GRID_N);
          else if (mv_r) col_d = wrap_step(col_q, 1'b0, GRID_N);
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          if (ships_remaining == '0)  phase_d = WON;
          else if (turns_left == '0)  phase_d = LOST;
          else                        phase_d = PLAY;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      default: phase_d = TITLE;
    endcase
    if (start_clr) begin
      phase_d = CLEAR;
      clr_d   = 1'b1;
      row_d   = '0;
      col_d   = '0;
      shots_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= TITLE;
      row_q    <= '0;
      col_q    <= '0;
      shots_q  <= '0;
      settle_q <= '0;
      bomb_q   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      row_q    <= row_d;
      col_q    <= col_d;
      shots_q  <= shots_d;
      settle_q <= settle_d;
      bomb_q   <= bomb_d;
      clr_q    <= clr_d;
    end
  end

  assign sprite_row  = row_q;
  assign sprite_col  = col_q;
  assign bomb        = bomb_q;
  assign board_clear = clr_q;
  assign phase       = phase_q;
  assign shots_fired = shots_q;

endmodule

// File: doc/bship_game_ctrl.md
Name: bship_game_ctrl

Overview:
- Top-level sequencer for the Battleship board datapath (the 10×10 cell-status / turns / ships-remaining block).
- Owns the game phase FSM: title, board clear, play, shot settle, win, lose.
- Owns the cursor (sprite row/col), with button edge detection and optional hold-to-repeat.
- Emits a single-cycle bomb pulse and a single-cycle board-clear pulse to the board datapath, and reads back turns_left and ships_remaining.

Parameters:
- GRID_N, 10: cells per row/column; cursor range 0..GRID_N-1.
- REPEAT_DELAY, 25_000_000: cycles a direction button must be held before the first auto-repeat move.
- REPEAT_RATE, 10_000_000: cycles between subsequent auto-repeat moves.
- SETTLE_CYCLES, 4: cycles waited after a bomb pulse before sampling turns_left / ships_remaining. Must be ≥3 (hit write, then sink write, then counter update).

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- btn_u, btn_d, btn_l, btn_r, btn_c, in, 1 each: debounced, clk-synchronous button levels.
- turns_left, in, 5: misses remaining, from board datapath.
- ships_remaining, in, 3: unsunk ships, from board datapath.
- sprite_row, out, 4: cursor row.
- sprite_col, out, 4: cursor column.
- bomb, out, 1: one-cycle fire pulse to datapath.
- board_clear, out, 1: one-cycle active-high clear pulse to datapath reset.
- phase, out, 3: current FSM state encoding.
- shots_fired, out, 7: count of bomb pulses issued since last clear; saturates at 127.

Behaviour:
- Reset (async assert, sync release): phase=TITLE, sprite_row=0, sprite_col=0, bomb=0, board_clear=0, shots_fired=0, all edge/repeat registers and counters cleared. Reset mid-settle abandons the shot; no further bomb is issued.
- Edges: a rising edge is btn & ~btn_d, registered per button. Every action below is taken on the rising edge, never on a held level, unless auto-repeat is in effect.
- FSM states and encodings:
  - TITLE=0: on btn_c edge → CLEAR.
  - CLEAR=1: board_clear=1 for exactly this cycle; cursor←(0,0); shots_fired←0; → PLAY next cycle.
  - PLAY=2:
    - Cursor moves are accepted only in this state.
    - On btn_c edge: bomb=1 for one cycle; shots_fired+1 (saturating); settle counter loaded; → SETTLE.
    - btn_c has priority over a direction move in the same cycle; that move is dropped.
  - SETTLE=3:
    - Counts SETTLE_CYCLES; all buttons ignored.
    - At terminal count: ships_remaining==0 → WON; else turns_left==0 → LOST; else → PLAY. WON wins if both conditions hold.
  - WON=4, LOST=5: cursor frozen; on btn_c edge → CLEAR.
  - Encodings 6 and 7 are unreachable; if ever entered → TITLE.
- Cursor moves:
  - Vertical and horizontal axes are independent, so one row move and one col move may occur in the same cycle.
  - up beats down; left beats right.
  - up decrements row; down increments row; left decrements col; right increments col.
  - Wrap-around: row 0 + up → GRID_N-1; GRID_N-1 + down → 0. Columns wrap the same way.
- Outputs are registered. bomb and board_clear go high the cycle after the triggering edge is registered and are never high together.
- A repeated bomb on an already-struck cell is still issued and counted. The datapath ignores it.

Optional Feature:
- Macro: BSHIP_AUTO_REPEAT_EN.
- Defined: a direction held continuously in PLAY moves once on its edge, again after REPEAT_DELAY cycles, then every REPEAT_RATE cycles. Release, leaving PLAY, or reset clears that direction's counter.
- Undefined: edge-only movement; repeat counters and parameters are unused and synthesize away.

Decomposition:
- Package bship_pkg holds:
  - phase enum/localparams TITLE..LOST;
  - GRID_N;
  - cursor width (4), turns width (5), ships width (3);
  - shot counter maximum (127).
- One sub-module, bship_btn_repeat: per-button edge detector plus repeat counter, outputting a single-cycle move strobe. It is instantiated four times (u/d/l/r). btn_c uses the same module with repeat tied off.

Test Plan:
- Reset, then btn_c pulse → board_clear high exactly 1 cycle, phase 0→1→2, cursor (0,0), shots_fired=0.
- In PLAY at (0,0): pulse btn_u, then btn_l → cursor (9,0), then (9,9). Pulse btn_u+btn_r same cycle → (8,0).
- In PLAY: btn_c pulse with turns_left=15, ships_remaining=5 → bomb high 1 cycle, phase=3 for SETTLE_CYCLES, back to 2, shots_fired=1. Direction pulses during SETTLE leave the cursor unchanged.
- Drive ships_remaining=0 and turns_left=0 before settle ends → phase=4 (WON). Then btn_c → CLEAR, shots_fired=0.
- turns_left=0, ships_remaining=2 at settle end → phase=5. Hold btn_c high for 100 cycles → exactly one CLEAR.
- With BSHIP_AUTO_REPEAT_EN, REPEAT_DELAY=8, REPEAT_RATE=4: hold btn_r for 20 cycles from col 0 → moves at edge, +8, +12, +16 → col 4. Assert reset_n=0 mid-hold → all outputs at reset values immediately.
